// File: rtl/data_memory_pkg.sv
// Shared constants for the CPU data memory: word width and default depth.
package data_memory_pkg;

    localparam int unsigned DM_WORD_LEN = 32;
    localparam int unsigned MEM_DEPTH   = 256;

endpackage

// File: rtl/data_memory.sv
// Word-addressed single-port data memory for the MEM stage: synchronous write,
// combinational gated read, asynchronous active-low clear of the whole array.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned WORD_LEN  = DM_WORD_LEN,
    parameter int unsigned DEPTH     = MEM_DEPTH,
    parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                writeM,
    input  logic                readM,
    input  logic [WORD_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] data,
    output logic [WORD_LEN-1:0] outdata
);

    logic [WORD_LEN-1:0]  mem_q [DEPTH];
    logic [ADDR_BITS-1:0] addr_idx_c;
    logic                 in_range_c;

    // Full-width compare so out-of-range addresses never alias onto low words.
    assign in_range_c = (address < WORD_LEN'(DEPTH));
    assign addr_idx_c = address[ADDR_BITS-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (writeM && in_range_c) begin
            mem_q[addr_idx_c] <= data;
        end
    end

    // Zero-latency read; no bypass, so a same-cycle write shows only after the edge.
    always_comb begin
        outdata = '0;
        if (readM && in_range_c) begin
            outdata = mem_q[addr_idx_c];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory plus hand-written multi-cycle sequences.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic        writeM;
    logic        readM;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] outdata;

    int n_tests;
    int n_fail;

    data_memory dut (
        .clk     (clk),
        .reset   (reset),
        .writeM  (writeM),
        .readM   (readM),
        .address (address),
        .data    (data),
        .outdata (outdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        writeM  = 1'b0;
        readM   = 1'b1;
        address = 32'd4;
        data    = 32'd0;
        #1;
        check("reset_out", outdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Post-reset reads
        add(0, 1, 4, 0, 0);
        add(0, 1, 5, 0, 0);
        add(0, 1, 94, 0, 0);
        // Writes with readM=0: output must stay 0
        add(1, 0, 4, 120, 0);
        add(1, 0, 5, 46, 0);
        add(1, 0, 12, 55, 0);
        add(1, 0, 14, 98, 0);
        add(1, 0, 40, 190, 0);
        add(1, 0, 84, 547, 0);
        // Read back
        add(0, 1, 4, 0, 120);
        add(0, 1, 5, 0, 46);
        add(0, 1, 12, 0, 55);
        add(0, 1, 14, 0, 98);
        add(0, 1, 40, 0, 190);
        add(0, 1, 84, 0, 547);
        // More writes, untouched and never-written words
        add(1, 0, 39, 23, 0);
        add(1, 0, 57, 547, 0);
        add(0, 1, 5, 0, 46);
        add(0, 1, 94, 0, 0);
        add(0, 1, 39, 0, 23);
        add(0, 1, 57, 0, 547);
        // writeM=0 with data present must not write
        add(0, 1, 94, 1234, 0);
        add(0, 1, 94, 0, 0);
        // Out-of-range write dropped, no aliasing onto 300 mod 256 = 44
        add(1, 1, 300, 999, 0);
        add(0, 1, 300, 0, 0);
        add(0, 1, 44, 0, 0);
        add(0, 1, 32'hFFFF_FF04, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            writeM  = vecs[i].we;
            readM   = vecs[i].re;
            address = vecs[i].addr;
            data    = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), outdata, vecs[i].exp);
        end

        // readM gating is combinational: no edge between the two checks
        @(negedge clk);
        writeM  = 1'b0;
        readM   = 1'b0;
        address = 32'd84;
        #1;
        check("readM0_84", outdata, 32'd0);
        readM = 1'b1;
        #1;
        check("readM1_84", outdata, 32'd547);

        // Same-address read+write: old value before edge, new value after
        @(negedge clk);
        writeM  = 1'b1;
        readM   = 1'b1;
        address = 32'd12;
        data    = 32'd77;
        #1;
        check("rw_pre_12", outdata, 32'd55);
        @(posedge clk);
        #1;
        check("rw_post_12", outdata, 32'd77);
        @(negedge clk);
        writeM = 1'b0;

        // Asynchronous clear between edges, with a pending write ignored
        address = 32'd40;
        #1;
        check("pre_clr_40", outdata, 32'd190);
        #1;
        reset = 1'b0;
        #1;
        check("clr_40_imm", outdata, 32'd0);
        writeM = 1'b1;
        data   = 32'd5;
        @(posedge clk);
        #1;
        check("clr_wr_ignored", outdata, 32'd0);
        @(negedge clk);
        writeM = 1'b0;
        reset  = 1'b1;
        #1;
        check("post_clr_40", outdata, 32'd0);
        address = 32'd84;
        #1;
        check("post_clr_84", outdata, 32'd0);
        address = 32'd12;
        #1;
        check("post_clr_12", outdata, 32'd0);

        // Out-of-range after reset, then a normal write still works
        @(negedge clk);
        writeM  = 1'b1;
        address = 32'd300;
        data    = 32'd321;
        @(negedge clk);
        writeM = 1'b0;
        #1;
        check("oor_300", outdata, 32'd0);
        address = 32'd44;
        #1;
        check("alias_44", outdata, 32'd0);
        writeM  = 1'b1;
        address = 32'd40;
        data    = 32'd7;
        @(negedge clk);
        writeM = 1'b0;
        #1;
        check("wr_after_clr_40", outdata, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
